// File: rtl/falafel_alloc_fsm.sv
// Free-list allocator: walks a singly linked free list through an LSU,
// first-fit allocates a block, splitting off the remainder when it is large enough.
package falafel_alloc_pkg;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    LSU_NOP                     = 3'd0,
    LSU_LOAD                    = 3'd1,
    LSU_LOCK                    = 3'd2,
    LSU_UNLOCK                  = 3'd3,
    LSU_EDIT_SIZE_AND_NEXT_ADDR = 3'd4,
    LSU_EDIT_NEXT_ADDR          = 3'd5
  } lsu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_t;

  typedef struct packed {
    logic    val;
    lsu_op_e lsu_op;
    header_t header;
  } header_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } rsp_header_t;

  typedef struct packed {
    logic        val;
    rsp_header_t header;
  } header_rsp_t;
endpackage

module falafel_alloc_fsm
  import falafel_alloc_pkg::*;
#(
  parameter logic [DATA_W-1:0] FREE_LIST_HEAD_ADDR = 'h10,
  parameter logic [DATA_W-1:0] MIN_BLOCK_SIZE      = 16,
  parameter logic [DATA_W-1:0] MAX_WALK            = 255,
  parameter logic [DATA_W-1:0] LOCK_ID             = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_req_val_i,
  output logic              alloc_req_rdy_o,
  input  logic [DATA_W-1:0] alloc_req_size_i,
  output logic              alloc_rsp_val_o,
  input  logic              alloc_rsp_rdy_i,
  output logic [DATA_W-1:0] alloc_rsp_addr_o,
  output logic              alloc_rsp_ok_o,
  output header_req_t       lsu_req_header_o,
  input  logic              lsu_ready_i,
  input  header_rsp_t       lsu_rsp_header_i,
  output logic              lsu_rsp_rdy_o
);

  typedef enum logic [4:0] {
    S_IDLE,
    S_LOCK_ISS,   S_LOCK_WAIT,
    S_HEAD_ISS,   S_HEAD_WAIT,
    S_CURR_ISS,   S_CURR_WAIT,
    S_DECIDE,
    S_REMAIN_ISS, S_REMAIN_WAIT,
    S_ALLOC_ISS,  S_ALLOC_WAIT,
    S_LINK_ISS,   S_LINK_WAIT,
    S_UNLOCK_ISS, S_UNLOCK_WAIT,
    S_RESPOND
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] size_q, size_d;
  logic [DATA_W-1:0] walk_q, walk_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] curr_q, curr_d;
  logic [DATA_W-1:0] curr_size_q, curr_size_d;
  logic [DATA_W-1:0] curr_next_q, curr_next_d;
  logic [DATA_W-1:0] link_q, link_d;
  logic              fail_q, fail_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      walk_q      <= '0;
      prev_q      <= '0;
      curr_q      <= '0;
      curr_size_q <= '0;
      curr_next_q <= '0;
      link_q      <= '0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      walk_q      <= walk_d;
      prev_q      <= prev_d;
      curr_q      <= curr_d;
      curr_size_q <= curr_size_d;
      curr_next_q <= curr_next_d;
      link_q      <= link_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    size_d           = size_q;
    walk_d           = walk_q;
    prev_d           = prev_q;
    curr_d           = curr_q;
    curr_size_d      = curr_size_q;
    curr_next_d      = curr_next_q;
    link_d           = link_q;
    fail_d           = fail_q;
    alloc_req_rdy_o  = 1'b0;
    alloc_rsp_val_o  = 1'b0;
    alloc_rsp_addr_o = '0;
    alloc_rsp_ok_o   = 1'b0;
    lsu_req_header_o = '0;
    lsu_rsp_rdy_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Ready is gated by reset so it reads 0 while the async reset is held.
        alloc_req_rdy_o = ~rst_i;
        if (alloc_req_val_i && !rst_i) begin
          size_d = alloc_req_size_i;
          walk_d = '0;
          prev_d = '0;
          curr_d = '0;
          if (alloc_req_size_i == '0) begin
            fail_d  = 1'b1;
            state_d = S_RESPOND;
          end else begin
            fail_d  = 1'b0;
            state_d = S_LOCK_ISS;
          end
        end
      end

      S_LOCK_ISS: begin
        lsu_req_header_o.val         = 1'b1;
        lsu_req_header_o.lsu_op      = LSU_LOCK;
        lsu_req_header_o.header.size = LOCK_ID;
        if (lsu_ready_i) state_d = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        lsu_rsp_rdy_o = 1'b1;
        if (lsu_rsp_header_i.val) state_d = S_HEAD_ISS;
      end

      S_HEAD_ISS: begin
        lsu_req_header_o.val         = 1'b1;
        lsu_req_header_o.lsu_op      = LSU_LOAD;
        lsu_req_header_o.header.addr = FREE_LIST_HEAD_ADDR;
        if (lsu_ready_i) state_d = S_HEAD_WAIT;
      end
      S_HEAD_WAIT: begin
        lsu_rsp_rdy_o = 1'b1;
        if (lsu_rsp_header_i.val) begin
          prev_d  = FREE_LIST_HEAD_ADDR;
          curr_d  = lsu_rsp_header_i.header.next_addr;
          state_d = S_CURR_ISS;
        end
      end

      // End-of-list / walk-limit check happens here, before any request is driven.
      S_CURR_ISS: begin
        if (curr_q == '0 || walk_q == MAX_WALK) begin
          fail_d  = 1'b1;
          state_d = S_UNLOCK_ISS;
        end else begin
          lsu_req_header_o.val         = 1'b1;
          lsu_req_header_o.lsu_op      = LSU_LOAD;
          lsu_req_header_o.header.addr = curr_q;
          if (lsu_ready_i) begin
            if (walk_q != '1) walk_d = walk_q + 1'b1;
            state_d = S_CURR_WAIT;
          end
        end
      end
      S_CURR_WAIT: begin
        lsu_rsp_rdy_o = 1'b1;
        if (lsu_rsp_header_i.val) begin
          curr_size_d = lsu_rsp_header_i.header.size;
          curr_next_d = lsu_rsp_header_i.header.next_addr;
          state_d     = S_DECIDE;
        end
      end

      S_DECIDE: begin
        if (curr_size_q < size_q) begin
          prev_d  = curr_q;
          curr_d  = curr_next_q;
          state_d = S_CURR_ISS;
        end else if ((curr_size_q - size_q) >= MIN_BLOCK_SIZE) begin
          state_d = S_REMAIN_ISS;
        end else begin
          link_d  = curr_next_q;
          state_d = S_LINK_ISS;
        end
      end

      S_REMAIN_ISS: begin
        lsu_req_header_o.val              = 1'b1;
        lsu_req_header_o.lsu_op           = LSU_EDIT_SIZE_AND_NEXT_ADDR;
        lsu_req_header_o.header.addr      = curr_q + size_q;
        lsu_req_header_o.header.size      = curr_size_q - size_q;
        lsu_req_header_o.header.next_addr = curr_next_q;
        if (lsu_ready_i) state_d = S_REMAIN_WAIT;
      end
      S_REMAIN_WAIT: begin
        lsu_rsp_rdy_o = 1'b1;
        if (lsu_rsp_header_i.val) state_d = S_ALLOC_ISS;
      end

      S_ALLOC_ISS: begin
        lsu_req_header_o.val         = 1'b1;
        lsu_req_header_o.lsu_op      = LSU_EDIT_SIZE_AND_NEXT_ADDR;
        lsu_req_header_o.header.addr = curr_q;
        lsu_req_header_o.header.size = size_q;
        if (lsu_ready_i) state_d = S_ALLOC_WAIT;
      end
      S_ALLOC_WAIT: begin
        lsu_rsp_rdy_o = 1'b1;
        if (lsu_rsp_header_i.val) begin
          link_d  = curr_q + size_q;
          state_d = S_LINK_ISS;
        end
      end

      S_LINK_ISS: begin
        lsu_req_header_o.val              = 1'b1;
        lsu_req_header_o.lsu_op           = LSU_EDIT_NEXT_ADDR;
        lsu_req_header_o.header.addr      = prev_q;
        lsu_req_header_o.header.next_addr = link_q;
        if (lsu_ready_i) state_d = S_LINK_WAIT;
      end
      S_LINK_WAIT: begin
        lsu_rsp_rdy_o = 1'b1;
        if (lsu_rsp_header_i.val) state_d = S_UNLOCK_ISS;
      end

      S_UNLOCK_ISS: begin
        lsu_req_header_o.val    = 1'b1;
        lsu_req_header_o.lsu_op = LSU_UNLOCK;
        if (lsu_ready_i) state_d = S_UNLOCK_WAIT;
      end
      S_UNLOCK_WAIT: begin
        lsu_rsp_rdy_o = 1'b1;
        if (lsu_rsp_header_i.val) state_d = S_RESPOND;
      end

      S_RESPOND: begin
        alloc_rsp_val_o  = 1'b1;
        alloc_rsp_addr_o = fail_q ? '0 : curr_q;
        alloc_rsp_ok_o   = ~fail_q;
        if (alloc_rsp_rdy_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/falafel_alloc_fsm.md
FALAFEL_ALLOC_FSM -- requirements
Module: falafel_alloc_fsm

Interface
REQ-001 SHALL have parameter FREE_LIST_HEAD_ADDR, default 'h10: address of the sentinel block whose next_addr field is the first free block.
REQ-002 SHALL have parameter MIN_BLOCK_SIZE, default 16: smallest remainder that is split off as a new free block.
REQ-003 SHALL have parameter MAX_WALK, default 255: maximum number of free blocks visited per request.
REQ-004 SHALL have parameter LOCK_ID, default 1: value written into the lock word by LOCK.
REQ-005 clk_i  in  1  single clock; all state SHALL be on its rising edge.
REQ-006 rst_i  in  1  reset; asynchronous, active-high.
REQ-007 alloc_req_val_i  in  1  allocation request valid.
REQ-008 alloc_req_rdy_o  out  1  block accepts a request.
REQ-009 alloc_req_size_i  in  DATA_W  requested size in bytes.
REQ-010 alloc_rsp_val_o  out  1  response valid.
REQ-011 alloc_rsp_rdy_i  in  1  consumer accepts the response.
REQ-012 alloc_rsp_addr_o  out  DATA_W  allocated block address; 0 on failure.
REQ-013 alloc_rsp_ok_o  out  1  1 means success.
REQ-014 lsu_req_header_o  out  header_req_t  request to the LSU (fields val, lsu_op, header.addr/size/next_addr).
REQ-015 lsu_ready_i  in  1  LSU is idle and samples lsu_req_header_o.
REQ-016 lsu_rsp_header_i  in  header_rsp_t  LSU response (fields val, header.size/next_addr).
REQ-017 lsu_rsp_rdy_o  out  1  block accepts the LSU response.

Function
REQ-018 LSU handshake: in each issue state the block SHALL drive lsu_req_header_o.val=1 and hold it until a cycle with lsu_ready_i=1. It SHALL then drop val, go to the matching wait state, assert lsu_rsp_rdy_o, and advance on the cycle lsu_rsp_header_i.val=1. Only one LSU operation SHALL be outstanding at a time.
REQ-019 States SHALL be: IDLE, LOCK, LOAD_HEAD, LOAD_CURR, DECIDE, WRITE_REMAIN, WRITE_ALLOC, LINK_PREV, UNLOCK, RESPOND. Every LSU-issuing state has an issue phase and a wait phase.
REQ-020 IDLE: alloc_req_rdy_o=1. On a request handshake the block SHALL register the size and clear the walk counter.
  - size=0: go to RESPOND with ok=0, with no LSU traffic.
  - otherwise: go to LOCK.
REQ-021 LOCK: issue lsu_op=LOCK with addr=0 and size=LOCK_ID, then go to LOAD_HEAD.
REQ-022 LOAD_HEAD: issue LOAD at FREE_LIST_HEAD_ADDR, then set prev=FREE_LIST_HEAD_ADDR and curr=rsp.next_addr.
REQ-023 Before every LOAD_CURR: if curr=0 or the walk counter equals MAX_WALK, set fail and go to UNLOCK. Otherwise issue LOAD at curr, capture curr_size and curr_next, and increment the walk counter (saturating).
REQ-024 DECIDE (unsigned, DATA_W wide):
  - curr_size < size: set prev=curr, curr=curr_next, and return to the REQ-023 check.
  - curr_size - size >= MIN_BLOCK_SIZE (split): go to WRITE_REMAIN.
  - otherwise (exact fit): go to LINK_PREV with link=curr_next.
REQ-025 WRITE_REMAIN: issue EDIT_SIZE_AND_NEXT_ADDR at curr+size with size=curr_size-size and next=curr_next. Then WRITE_ALLOC: issue EDIT_SIZE_AND_NEXT_ADDR at curr with size=size and next=0. Then set link=curr+size and go to LINK_PREV.
REQ-026 LINK_PREV: issue EDIT_NEXT_ADDR at prev with next_addr=link, then go to UNLOCK.
REQ-027 UNLOCK: issue lsu_op=UNLOCK, then go to RESPOND.
REQ-028 RESPOND: drive alloc_rsp_val_o=1 with addr=curr, ok=1 on success, or addr=0, ok=0 on failure. Outputs SHALL stay stable until alloc_rsp_rdy_i=1, then go to IDLE. alloc_req_rdy_o SHALL be 0 in every state except IDLE.
REQ-029 Address arithmetic SHALL wrap modulo 2^DATA_W. No overflow detection.
REQ-030 Response latency SHALL be one cycle after the final LSU response; there are no other added bubbles.

Reset
REQ-031 While rst_i=1 the block SHALL be in IDLE and hold:
  - alloc_req_rdy_o=0
  - alloc_rsp_val_o=0, alloc_rsp_addr_o=0, alloc_rsp_ok_o=0
  - lsu_req_header_o all-zero
  - lsu_rsp_rdy_o=0
  - all counters and registers at 0
REQ-032 Reset asserted mid-operation SHALL abort immediately, with no UNLOCK issued. Lock recovery is a system-level responsibility.

Verification
REQ-033 Split: head.next=0x100, block 0x100 {size 64, next 0}, alloc 16. Required LSU sequence: LOCK, LOAD 0x10, LOAD 0x100, EDIT 0x110 {48,0}, EDIT 0x100 {16,0}, EDIT_NEXT 0x10:=0x110, UNLOCK. Required response: addr=0x100, ok=1.
REQ-034 Exact fit: block 0x100 {size 24, next 0x300}, alloc 16. Required: no size writes, EDIT_NEXT 0x10:=0x300, response addr=0x100, ok=1.
REQ-035 Walk: 0x100 {8, 0x200} then 0x200 {32, 0}, alloc 32. Required: EDIT_NEXT 0x100:=0, response addr=0x200, ok=1.
REQ-036 Empty list: head.next=0. Required: LOCK, LOAD, UNLOCK, then response addr=0, ok=0. With size=0, the response is ok=0 and no LSU request is issued.
REQ-037 Handshakes:
  - lsu_ready_i low for 5 cycles: val held and header stable throughout.
  - alloc_rsp_rdy_i low for 3 cycles: response held.
  - rst_i pulsed during LOAD_CURR: all outputs 0 within the same cycle.
